srl16_fifo_ctrl: RTL
====================

# srl16_fifo_ctrl

Small-FIFO controller built on SRL16E-style addressable shift-register storage. It sequences the shift-enable and read address of a WIDTH-bit bank of 16-deep shift registers, tracks occupancy, and presents a registered output stage with valid/ready handshakes on both sides. It is used as the low-cost elastic buffer between datapath stages that would otherwise need flop-based FIFOs.

## Interface
- WIDTH, 8, data width in bits (1..64).
- DEPTH, 16, shift-register entries (2..16); total capacity DEPTH+1 including the output register.

- C  input  1  clock, all state on rising edge.
- CLR  input  1  asynchronous active-high reset.
- in_data  input  WIDTH  write data.
- in_valid  input  1  write request.
- in_ready  output  1  storage can accept; a push occurs when in_valid && in_ready.
- out_data  output  WIDTH  registered head-of-queue data.
- out_valid  output  1  out_data holds a valid entry.
- out_ready  input  1  consumer accepts; a pop occurs when out_valid && out_ready.
- count  output  5  total occupancy 0..DEPTH+1 (present only with SRL_FIFO_COUNT_EN).

## Operation
- Storage: WIDTH shift registers of DEPTH entries, shift enable srl_ce, shared read address srl_a[3:0]. Storage contents have no reset (SRL semantics).
- Push: srl_ce=1 shifts in_data into entry 0; older entries move up by one.
- Head of storage is entry srl_a = srl_cnt-1; srl_cnt is a 5-bit counter 0..DEPTH.
- Load: output register loads storage[srl_a] when srl_cnt!=0 and (out_valid==0 or pop). Load decrements srl_cnt.
- Counter update per cycle: push only +1; load only -1; push and load together unchanged (read address samples pre-shift contents, so the entry is taken from srl_a before the shift moves it; the address is the same before and after).
- in_ready = (srl_cnt != DEPTH), combinational from the counter only; never depends on out_ready.
- Pop without load (srl_cnt==0): out_valid clears next cycle.
- No bypass: every entry passes through storage.
- States (derived from srl_cnt, out_valid):
  - IDLE: srl_cnt=0, out_valid=0. Push -> LOADING.
  - LOADING: srl_cnt>=1, out_valid=0. Next cycle loads -> STREAM or HOLD.
  - HOLD: srl_cnt=0, out_valid=1. Push -> STREAM; pop -> IDLE.
  - STREAM: 1<=srl_cnt<DEPTH, out_valid=1.
  - FULL: srl_cnt=DEPTH, out_valid=1; in_ready=0; pop -> STREAM (load frees one slot).
- Push while in_ready=0 is ignored (no overwrite, no error flag).

## Timing
- Reset values (asynchronous on CLR rise): srl_cnt=0, out_valid=0, out_data=0, in_ready=1, count=0.
- CLR mid-operation discards all entries immediately; storage contents remain but are unreachable.
- Latency: push at edge N -> out_valid=1 after edge N+1 (entry in storage after N, loaded at N+1).
- Throughput: one push and one pop per cycle sustained in STREAM.
- in_ready rises the cycle after the first load from FULL.
- out_data stable while out_valid=1 and out_ready=0.
- Ordering strictly FIFO; wrap-around not applicable (shift storage, no write pointer).

## Configuration
- SRL_FIFO_COUNT_EN defined: count port present, count = srl_cnt + out_valid, registered-consistent with state (updated same edge).
- Not defined: count port and its logic absent; behaviour otherwise identical.

## Test plan
- Reset then push 0xA5 once, out_ready=1 -> out_valid=1 two edges after push, out_data=0xA5, then IDLE; count 1 then 0.
- Push 17 values 0..16 with out_ready=0 (DEPTH=16) -> in_ready=0 after 17th accepted, count=17, out_data=0; 18th push ignored.
- From FULL, raise out_ready for 17 cycles -> outputs 0..16 in order, in_ready=1 one cycle after first pop.
- Continuous push and pop at 1/cycle for 100 cycles -> no bubbles after fill, srl_cnt constant, data in order.
- Random in_valid/out_ready 10k cycles vs reference queue model -> no loss, duplication or reorder.
- Assert CLR with 9 entries queued -> out_valid=0, in_ready=1, count=0 immediately; next push 0x3C emerges as first output.

Source files
------------

// File: rtl/srl16_fifo_ctrl.sv
// rtl/srl16_fifo_ctrl.sv - SRL16-style shift-register FIFO controller with registered output stage
// Optional occupancy port enabled by defining SRL_FIFO_COUNT_EN.
module srl16_fifo_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             C,
  input  logic             CLR,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
`ifdef SRL_FIFO_COUNT_EN
  input  logic             out_ready,
  output logic [4:0]       count
`else
  input  logic             out_ready
`endif
);

  // Physical shift bank always has 16 taps; DEPTH only limits how many are used.
  logic [WIDTH-1:0] srl [16];
  logic [4:0]       srl_cnt;
  logic [3:0]       srl_a;
  logic             srl_ce;
  logic             pop;
  logic             load;

  assign in_ready = (srl_cnt != 5'(DEPTH));
  assign srl_ce   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign load     = (srl_cnt != 5'd0) && (!out_valid || pop);
  assign srl_a    = 4'(srl_cnt - 5'd1);

  // Storage carries no reset; entries beyond srl_cnt are simply unreachable.
  always_ff @(posedge C) begin
    if (srl_ce) begin
      srl[0] <= in_data;
      for (int i = 15; i > 0; i--) begin
        srl[i] <= srl[i-1];
      end
    end
  end

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      srl_cnt   <= 5'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // Read address samples pre-shift contents, so push+load leaves srl_cnt unchanged.
      case ({srl_ce, load})
        2'b10:   srl_cnt <= srl_cnt + 5'd1;
        2'b01:   srl_cnt <= srl_cnt - 5'd1;
        default: srl_cnt <= srl_cnt;
      endcase
      if (load) begin
        out_data  <= srl[srl_a];
        out_valid <= 1'b1;
      end else if (pop) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef SRL_FIFO_COUNT_EN
  assign count = srl_cnt + 5'(out_valid);
`endif

endmodule
